// File: rtl/instruction_decode_pkg.sv
// instruction_decode_pkg: opcodes and instruction field positions shared by the processor.
package instruction_decode_pkg;

    typedef enum logic [1:0] {
        OP_MOV = 2'b00,
        OP_ADD = 2'b01,
        OP_LDI = 2'b10,
        OP_JMP = 2'b11
    } opcode_e;

    localparam int OP_MSB = 7;
    localparam int OP_LSB = 6;
    localparam int RD_MSB = 5;
    localparam int RD_LSB = 4;
    localparam int RS_MSB = 3;
    localparam int RS_LSB = 2;
    localparam int IMM_W  = 4;
    localparam int TGT_W  = 6;

endpackage

// File: rtl/reg_file_4x8.sv
// reg_file_4x8: register file with one write port, two read ports and a debug read port.
module reg_file_4x8 #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [1:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        raddr_a,
    input  logic [1:0]        raddr_b,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a  = regs[raddr_a];
        rdata_b  = regs[raddr_b];
        dbg_data = regs[dbg_sel];
    end

endmodule

// File: rtl/instruction_decode.sv
// instruction_decode: IR capture plus single-cycle execute; a taken JMP flushes the next instruction.
module instruction_decode
    import instruction_decode_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] jumpTarget,
    output logic              jumpTaken,
    input  logic [1:0]        dbgSel,
    output logic [DATA_W-1:0] dbgData,
    output logic [DATA_W-1:0] retiredCount
);

    logic [DATA_W-1:0] ir;
    logic              ir_valid;
    opcode_e           op;
    logic [1:0]        rd;
    logic [1:0]        rs;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] wdata;
    logic              we;

    always_comb begin
        op         = opcode_e'(ir[OP_MSB:OP_LSB]);
        rd         = ir[RD_MSB:RD_LSB];
        rs         = ir[RS_MSB:RS_LSB];
        jumpTaken  = ir_valid && op == OP_JMP;
        jumpTarget = jumpTaken ? DATA_W'(ir[TGT_W-1:0]) : '0;
        we         = ir_valid && op != OP_JMP;
        wdata      = op == OP_ADD ? rd_val + rs_val :
                     op == OP_LDI ? DATA_W'(ir[IMM_W-1:0]) : rs_val;
    end

    // The instruction captured alongside a taken jump is the wrong path: keep it as a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir           <= '0;
            ir_valid     <= 1'b0;
            retiredCount <= '0;
        end else begin
            ir       <= instruction;
            ir_valid <= !jumpTaken;
            if (ir_valid) retiredCount <= retiredCount + 1'b1;
        end
    end

    reg_file_4x8 #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS)
    ) u_regs (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .waddr   (rd),
        .wdata   (wdata),
        .raddr_a (rd),
        .raddr_b (rs),
        .dbg_sel (dbgSel),
        .rdata_a (rd_val),
        .rdata_b (rs_val),
        .dbg_data(dbgData)
    );

endmodule

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode: directed vectors with hand-computed expectations for instruction_decode.
module tb_instruction_decode;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] instruction;
    logic [7:0] jumpTarget;
    logic       jumpTaken;
    logic [1:0] dbgSel;
    logic [7:0] dbgData;
    logic [7:0] retiredCount;
    int         total = 0;
    int         bad = 0;

    instruction_decode dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .jumpTarget  (jumpTarget),
        .jumpTaken   (jumpTaken),
        .dbgSel      (dbgSel),
        .dbgData     (dbgData),
        .retiredCount(retiredCount)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkreg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
        dbgSel = idx;
        #1;
        chk(tag, dbgData, exp);
    endtask

    // Present an instruction, let the next rising edge capture it, return at the falling edge.
    task automatic issue(input logic [7:0] ins);
        instruction = ins;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        logic [7:0] dbl [5];
        dbl = '{8'd30, 8'd60, 8'd120, 8'd240, 8'd224};
        reset = 1'b0;
        instruction = 8'h00;
        dbgSel = 2'd0;
        @(negedge clk);
        chk("rst_jt", {7'd0, jumpTaken}, 8'd0);
        chk("rst_tgt", jumpTarget, 8'd0);
        chk("rst_cnt", retiredCount, 8'd0);
        chkreg("rst_r0", 2'd0, 8'd0);
        reset = 1'b1;

        // LDI r1,5 / LDI r2,3 / ADD r1,r2 / MOV r3,r1
        issue(8'h95);
        issue(8'hA3);
        issue(8'h58);
        issue(8'h34);
        issue(8'h00);
        chkreg("seq_r1", 2'd1, 8'd8);
        chkreg("seq_r2", 2'd2, 8'd3);
        chkreg("seq_r3", 2'd3, 8'd8);
        chk("seq_cnt", retiredCount, 8'd4);

        // LDI r0,15 then ADD r0,r0 five times, wrapping past 255
        do_reset();
        issue(8'h8F);
        issue(8'h40);
        chkreg("dbl_ldi", 2'd0, 8'd15);
        for (int k = 0; k < 5; k++) begin
            issue(k < 4 ? 8'h40 : 8'h00);
            chkreg($sformatf("dbl_%0d", k), 2'd0, dbl[k]);
        end
        chk("dbl_cnt", retiredCount, 8'd6);

        // JMP 0x10 flushes the following LDI r1,5
        do_reset();
        issue(8'h97);
        issue(8'hD0);
        chk("jmp_jt", {7'd0, jumpTaken}, 8'd1);
        chk("jmp_tgt", jumpTarget, 8'h10);
        issue(8'h95);
        chk("jmp_jt_off", {7'd0, jumpTaken}, 8'd0);
        chk("jmp_tgt_off", jumpTarget, 8'h00);
        issue(8'h00);
        chkreg("jmp_r1", 2'd1, 8'd7);
        chk("jmp_cnt", retiredCount, 8'd2);

        // Back-to-back JMPs: second one flushed, never issues 0x15
        do_reset();
        issue(8'hD0);
        chk("jj_jt1", {7'd0, jumpTaken}, 8'd1);
        chk("jj_tgt1", jumpTarget, 8'h10);
        issue(8'hD5);
        chk("jj_jt2", {7'd0, jumpTaken}, 8'd0);
        chk("jj_tgt2", jumpTarget, 8'h00);
        issue(8'h00);
        chk("jj_jt3", {7'd0, jumpTaken}, 8'd0);
        chk("jj_cnt", retiredCount, 8'd1);

        // Reset asserted mid-cycle with LDI r1,5 in IR
        do_reset();
        issue(8'hA3);
        issue(8'h95);
        chkreg("mid_pre_r2", 2'd2, 8'd3);
        reset = 1'b0;
        #1;
        chkreg("mid_r0", 2'd0, 8'd0);
        chkreg("mid_r2", 2'd2, 8'd0);
        chk("mid_jt", {7'd0, jumpTaken}, 8'd0);
        chk("mid_cnt", retiredCount, 8'd0);
        @(negedge clk);
        chkreg("mid_r1", 2'd1, 8'd0);
        reset = 1'b1;
        issue(8'h97);
        issue(8'h00);
        chkreg("post_r1", 2'd1, 8'd7);
        chk("post_cnt", retiredCount, 8'd1);

        // 256 LDIs wrap retiredCount to 0
        do_reset();
        for (int k = 0; k < 256; k++) issue(8'hA1);
        chk("wrap_255", retiredCount, 8'd255);
        issue(8'h00);
        chk("wrap_0", retiredCount, 8'd0);
        chkreg("wrap_r2", 2'd2, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
